// File: rtl/piso_serializer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// piso_serializer_ctrl_pkg : shared state encoding and counter sizing helper
// Rev 1.0
// ============================================================================
package piso_serializer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } piso_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_serializer_ctrl_if.sv
`default_nettype none
// ============================================================================
// piso_serializer_ctrl_if : parallel handshake in, framed serial stream out
// Rev 1.0
// ============================================================================
interface piso_serializer_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             so;
  logic             so_valid;
  logic             sof;
  logic             eof;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_data,
    input  in_ready, so, so_valid, sof, eof, busy, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, so, so_valid, sof, eof, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/piso_serializer_ctrl_bit_timer.sv
`default_nettype none
// ============================================================================
// piso_bit_timer : holds each serial bit for DIV clocks, ticks on the last one
// Rev 1.0
// ============================================================================
module piso_bit_timer
  import piso_serializer_ctrl_pkg::*;
#(
  parameter int DIV = 1
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  clr_i,
  input  wire  en_i,
  output logic bit_tick_o
);
  localparam int             DW       = cnt_width(DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;

  assign bit_tick_o = en_i && (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr_i) begin
      div_cnt_d = '0;
    end else if (en_i) begin
      div_cnt_d = bit_tick_o ? '0 : div_cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) div_cnt_q <= '0;
    else     div_cnt_q <= div_cnt_d;
  end
endmodule
`default_nettype wire

// File: rtl/piso_serializer_ctrl.sv
`default_nettype none
// ============================================================================
// piso_serializer_ctrl : loads a word on handshake, shifts it out framed by sof/eof/done
// Rev 1.0
// ============================================================================
module piso_serializer_ctrl
  import piso_serializer_ctrl_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  wire                    clk,
  input  wire                    rst,
  piso_serializer_ctrl_if.slave  ser
);
  localparam int            BW       = cnt_width(WIDTH);
  localparam int            GW       = cnt_width(GAP);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             done_q, done_d;
  logic             accept;
  logic             shifting;
  logic             bit_tick;

  assign accept   = ser.in_valid && (state_q == ST_IDLE);
  assign shifting = (state_q == ST_SHIFT);

  piso_bit_timer #(.DIV(DIV)) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (accept),
    .en_i       (shifting),
    .bit_tick_o (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d   = ser.in_data;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            done_d    = 1'b1;
            gap_cnt_d = '0;
            state_d   = (GAP > 0) ? ST_GAP : ST_IDLE;
          end else begin
            shreg_d   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, shreg_q[WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d   = ST_IDLE;
        else                       gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
    end
  end

  // Output decode is purely from registered state; so is forced low off-frame.
  assign ser.in_ready = (state_q == ST_IDLE);
  assign ser.so_valid = shifting;
  assign ser.so       = shifting && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
  assign ser.sof      = shifting && (bit_cnt_q == '0);
  assign ser.eof      = shifting && (bit_cnt_q == LAST_BIT);
  assign ser.busy     = (state_q == ST_SHIFT) || (state_q == ST_GAP);
  assign ser.done     = done_q;
endmodule
`default_nettype wire

// File: tb/tb_piso_serializer_ctrl.sv
`default_nettype none
// ============================================================================
// tb_piso_serializer_ctrl : directed checks over four parameter sets
// Rev 1.0
// ============================================================================
module tb_piso_serializer_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  piso_serializer_ctrl_if #(.WIDTH(4)) if0 ();
  piso_serializer_ctrl_if #(.WIDTH(4)) if1 ();
  piso_serializer_ctrl_if #(.WIDTH(4)) if2 ();
  piso_serializer_ctrl_if #(.WIDTH(4)) if3 ();

  piso_serializer_ctrl #(.WIDTH(4), .DIV(1), .MSB_FIRST(1'b1), .GAP(0))
    u0 (.clk(clk), .rst(rst), .ser(if0.slave));
  piso_serializer_ctrl #(.WIDTH(4), .DIV(1), .MSB_FIRST(1'b0), .GAP(0))
    u1 (.clk(clk), .rst(rst), .ser(if1.slave));
  piso_serializer_ctrl #(.WIDTH(4), .DIV(3), .MSB_FIRST(1'b1), .GAP(0))
    u2 (.clk(clk), .rst(rst), .ser(if2.slave));
  piso_serializer_ctrl #(.WIDTH(4), .DIV(1), .MSB_FIRST(1'b1), .GAP(2))
    u3 (.clk(clk), .rst(rst), .ser(if3.slave));

  // Observed vector: {so, so_valid, sof, eof, busy, in_ready, done}
  logic [6:0] obs0, obs1, obs2, obs3;
  assign obs0 = {if0.so, if0.so_valid, if0.sof, if0.eof, if0.busy, if0.in_ready, if0.done};
  assign obs1 = {if1.so, if1.so_valid, if1.sof, if1.eof, if1.busy, if1.in_ready, if1.done};
  assign obs2 = {if2.so, if2.so_valid, if2.sof, if2.eof, if2.busy, if2.in_ready, if2.done};
  assign obs3 = {if3.so, if3.so_valid, if3.sof, if3.eof, if3.busy, if3.in_ready, if3.done};

  localparam logic [6:0] V_IDLE      = 7'b0000010;
  localparam logic [6:0] V_DONE_IDLE = 7'b0000011;
  localparam logic [6:0] V_DONE_GAP  = 7'b0000101;
  localparam logic [6:0] V_GAP       = 7'b0000100;

  // Expected vector while bit index b (0..3) with value v is on so.
  function automatic logic [6:0] v_shift(input logic v, input int b);
    return {v, 1'b1, (b == 0), (b == 3), 1'b1, 1'b0, 1'b0};
  endfunction

  task automatic idle_all();
    if0.in_valid = 0; if0.in_data = '0;
    if1.in_valid = 0; if1.in_data = '0;
    if2.in_valid = 0; if2.in_data = '0;
    if3.in_valid = 0; if3.in_data = '0;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (obs0 !== V_IDLE) begin failures++; $display("FAIL reset_u0 got=%b exp=%b", obs0, V_IDLE); end
    if (obs1 !== V_IDLE) begin failures++; $display("FAIL reset_u1 got=%b exp=%b", obs1, V_IDLE); end
    if (obs2 !== V_IDLE) begin failures++; $display("FAIL reset_u2 got=%b exp=%b", obs2, V_IDLE); end
    if (obs3 !== V_IDLE) begin failures++; $display("FAIL reset_u3 got=%b exp=%b", obs3, V_IDLE); end
  endtask

  task automatic test_msb_first();
    logic [3:0] bits = 4'b1011;  // sent order 1,0,1,1
    logic [6:0] exp;
    @(negedge clk); if0.in_valid = 1; if0.in_data = 4'b1011;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if0.in_valid = 0;
      exp = (c <= 4) ? v_shift(bits[4-c], c-1) : (c == 5) ? V_DONE_IDLE : V_IDLE;
      checks++;
      if (obs0 !== exp) begin failures++; $display("FAIL msb_first c=%0d got=%b exp=%b", c, obs0, exp); end
    end
  endtask

  task automatic test_lsb_first();
    logic [3:0] order = 4'b1101;  // sent order 1,1,0,1 (MSB of 'order' first)
    logic [6:0] exp;
    @(negedge clk); if1.in_valid = 1; if1.in_data = 4'b1011;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if1.in_valid = 0;
      exp = (c <= 4) ? v_shift(order[4-c], c-1) : (c == 5) ? V_DONE_IDLE : V_IDLE;
      checks++;
      if (obs1 !== exp) begin failures++; $display("FAIL lsb_first c=%0d got=%b exp=%b", c, obs1, exp); end
    end
  endtask

  task automatic test_div3();
    logic [3:0] bits = 4'b0110;
    logic [6:0] exp;
    @(negedge clk); if2.in_valid = 1; if2.in_data = 4'b0110;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if2.in_valid = 0;
      exp = (c <= 12) ? v_shift(bits[3-(c-1)/3], (c-1)/3) : (c == 13) ? V_DONE_IDLE : V_IDLE;
      checks++;
      if (obs2 !== exp) begin failures++; $display("FAIL div3 c=%0d got=%b exp=%b", c, obs2, exp); end
    end
  endtask

  task automatic test_back_to_back_gap0();
    logic [3:0] a = 4'b1011;
    logic [3:0] b = 4'b0101;
    logic [6:0] exp;
    @(negedge clk); if0.in_valid = 1; if0.in_data = a;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) if0.in_data = b;
      if (c == 6) if0.in_valid = 0;
      if (c <= 4)       exp = v_shift(a[4-c], c-1);
      else if (c == 5)  exp = V_DONE_IDLE;
      else if (c <= 9)  exp = v_shift(b[9-c], c-6);
      else if (c == 10) exp = V_DONE_IDLE;
      else              exp = V_IDLE;
      checks++;
      if (obs0 !== exp) begin failures++; $display("FAIL b2b_gap0 c=%0d got=%b exp=%b", c, obs0, exp); end
    end
  endtask

  task automatic test_back_to_back_gap2();
    logic [3:0] a = 4'b1011;
    logic [3:0] b = 4'b0101;
    logic [6:0] exp;
    @(negedge clk); if3.in_valid = 1; if3.in_data = a;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) if3.in_data = b;
      if (c == 8) if3.in_valid = 0;
      if (c <= 4)       exp = v_shift(a[4-c], c-1);
      else if (c == 5)  exp = V_DONE_GAP;
      else if (c == 6)  exp = V_GAP;
      else if (c == 7)  exp = V_IDLE;
      else if (c <= 11) exp = v_shift(b[11-c], c-8);
      else if (c == 12) exp = V_DONE_GAP;
      else if (c == 13) exp = V_GAP;
      else              exp = V_IDLE;
      checks++;
      if (obs3 !== exp) begin failures++; $display("FAIL b2b_gap2 c=%0d got=%b exp=%b", c, obs3, exp); end
    end
  endtask

  task automatic test_ignore_in_valid();
    logic [3:0] bits = 4'b1011;
    logic [6:0] exp;
    @(negedge clk); if0.in_valid = 1; if0.in_data = 4'b1011;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 3) begin
        if0.in_valid = c[0];
        if0.in_data  = (c == 2) ? 4'b0100 : 4'b0000;
      end else begin
        if0.in_valid = 0;
      end
      exp = (c <= 4) ? v_shift(bits[4-c], c-1) : (c == 5) ? V_DONE_IDLE : V_IDLE;
      checks++;
      if (obs0 !== exp) begin failures++; $display("FAIL ignore c=%0d got=%b exp=%b", c, obs0, exp); end
    end
  endtask

  task automatic test_rst_mid_frame();
    logic [3:0] a = 4'b1011;
    logic [3:0] f = 4'b0110;
    logic [6:0] exp;
    @(negedge clk); if0.in_valid = 1; if0.in_data = a;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if0.in_valid = 0;
      rst = (c == 3);
      exp = (c <= 3) ? v_shift(a[4-c], c-1) : V_IDLE;
      checks++;
      if (obs0 !== exp) begin failures++; $display("FAIL rst_mid c=%0d got=%b exp=%b", c, obs0, exp); end
    end
    if0.in_valid = 1; if0.in_data = f;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if0.in_valid = 0;
      exp = (c <= 4) ? v_shift(f[4-c], c-1) : (c == 5) ? V_DONE_IDLE : V_IDLE;
      checks++;
      if (obs0 !== exp) begin failures++; $display("FAIL rst_refill c=%0d got=%b exp=%b", c, obs0, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_div3();
    test_back_to_back_gap0();
    test_back_to_back_gap2();
    test_ignore_in_valid();
    test_rst_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
